// File: rtl/rgb_pkg.sv
// Shared widths, byte offsets and colour struct for the RGB PWM driver.
// The RGB_PWM_FADE_EN macro changes only rgb_pwm_channel.
package rgb_pkg;

    localparam int unsigned RGB_W = 24;
    localparam int unsigned CH_W  = 8;
    localparam int unsigned R_MSB = 23;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned B_MSB = 7;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic rgb_t unpack_rgb(input logic [RGB_W-1:0] word);
        rgb_t c;
        c.r = word[R_MSB -: CH_W];
        c.g = word[G_MSB -: CH_W];
        c.b = word[B_MSB -: CH_W];
        return c;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: duty register, registered comparator output and, when RGB_PWM_FADE_EN
// is defined, a target register that duty walks toward one step per PWM period.
module rgb_pwm_channel
    import rgb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [CH_W-1:0] tick_cnt_d_i,
    input  logic            boundary_i,
    input  logic            load_i,
    input  logic [CH_W-1:0] value_i,
    output logic            led_o
);

    logic [CH_W-1:0] duty_q, duty_d;
    logic            led_q, led_d;

`ifdef RGB_PWM_FADE_EN
    logic [CH_W-1:0] tgt_q, tgt_d;

    // The step on a load boundary already heads toward the freshly loaded target.
    always_comb begin
        tgt_d  = load_i ? value_i : tgt_q;
        duty_d = duty_q;
        if (boundary_i) begin
            if (duty_q < tgt_d) begin
                duty_d = duty_q + CH_W'(1);
            end else if (duty_q > tgt_d) begin
                duty_d = duty_q - CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q <= '0;
        end else begin
            tgt_q <= tgt_d;
        end
    end
`else
    always_comb begin
        duty_d = (boundary_i && load_i) ? value_i : duty_q;
    end
`endif

    // Compare against next-state tick and duty so the output lines up with tick_cnt.
    always_comb begin
        led_d = (tick_cnt_d_i < duty_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with a one-deep colour buffer applied at period
// boundaries. Define RGB_PWM_FADE_EN to make duty fade one step per period toward the colour.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             rgb_valid,
    output logic             rgb_ready,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_start
);

    localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

    logic [15:0]     pre_cnt_q, pre_cnt_d;
    logic [CH_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick_en;
    logic            boundary;
    logic            accept;
    logic            load;
    rgb_t            pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic            period_start_q;

    always_comb begin
        tick_en    = (pre_cnt_q == PreMax);
        pre_cnt_d  = tick_en ? '0 : pre_cnt_q + 16'd1;
        tick_cnt_d = tick_cnt_q;
        if (tick_en) begin
            tick_cnt_d = tick_cnt_q + CH_W'(1);
        end
        boundary = tick_en && (tick_cnt_q == '1);
    end

    // Accept needs an empty buffer and load needs a full one, so they never coincide.
    always_comb begin
        accept      = rgb_valid && !pend_full_q;
        load        = boundary && pend_full_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (accept) begin
            pend_d      = unpack_rgb(rgb_in);
            pend_full_d = 1'b1;
        end else if (load) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            tick_cnt_q     <= '0;
            pend_q         <= '0;
            pend_full_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            tick_cnt_q     <= tick_cnt_d;
            pend_q         <= pend_d;
            pend_full_q    <= pend_full_d;
            period_start_q <= boundary;
        end
    end

    assign rgb_ready    = !pend_full_q;
    assign period_start = period_start_q;

    rgb_pwm_channel u_ch_r (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_cnt_d_i (tick_cnt_d),
        .boundary_i   (boundary),
        .load_i       (load),
        .value_i      (pend_q.r),
        .led_o        (led_r)
    );

    rgb_pwm_channel u_ch_g (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_cnt_d_i (tick_cnt_d),
        .boundary_i   (boundary),
        .load_i       (load),
        .value_i      (pend_q.g),
        .led_o        (led_g)
    );

    rgb_pwm_channel u_ch_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_cnt_d_i (tick_cnt_d),
        .boundary_i   (boundary),
        .load_i       (load),
        .value_i      (pend_q.b),
        .led_o        (led_b)
    );

endmodule
